// File: rtl/all_gates_pkg.sv
// Shared types, gate bit positions and the golden truth table for the
// two-input gate-library checker.
package all_gates_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    localparam int NUM_VEC   = 4;
    localparam int NUM_GATES = 7;

    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NOT_B  = 2;
    localparam int NAND_B = 3;
    localparam int NOR_B  = 4;
    localparam int XOR_B  = 5;
    localparam int XNOR_B = 6;

    // idx is the stimulus vector {a,b}; NOT only depends on a.
    function automatic logic [NUM_GATES-1:0] golden(input logic [1:0] idx);
        logic [NUM_GATES-1:0] r;
        logic va;
        logic vb;
        va        = idx[1];
        vb        = idx[0];
        r         = '0;
        r[AND_B]  = va & vb;
        r[OR_B]   = va | vb;
        r[NOT_B]  = ~va;
        r[NAND_B] = ~(va & vb);
        r[NOR_B]  = ~(va | vb);
        r[XOR_B]  = va ^ vb;
        r[XNOR_B] = ~(va ^ vb);
        return r;
    endfunction

endpackage

// File: rtl/all_gates_golden.sv
// Combinational expected-output model: maps the current vector index to the
// seven reference gate outputs.
module all_gates_golden
    import all_gates_pkg::*;
(
    input  logic [1:0]           i_idx,
    output logic [NUM_GATES-1:0] o_expected
);

    assign o_expected = golden(i_idx);

endmodule

// File: rtl/all_gates_checker.sv
// Drives {a,b} through 00..11, waits SETTLE_CYCLES (legal 1..15) per vector,
// then compares the DUT gate outputs with the golden model and reports masks.
module all_gates_checker
    import all_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_out,
    input  logic       or_out,
    input  logic       not_out,
    input  logic       nand_out,
    input  logic       nor_out,
    input  logic       xor_out,
    input  logic       xnor_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [6:0] fail_bits
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_VEC - 1);

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [3:0]            r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [2:0]            r_err;
    logic [3:0]            r_fvec;
    logic [NUM_GATES-1:0]  r_fbits;

    state_t                w_state;
    logic [1:0]            w_idx;
    logic [3:0]            w_cnt;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_pass;
    logic [2:0]            w_err;
    logic [3:0]            w_fvec;
    logic [NUM_GATES-1:0]  w_fbits;

    logic [NUM_GATES-1:0]  w_obs;
    logic [NUM_GATES-1:0]  w_exp;
    logic [NUM_GATES-1:0]  w_diff;
    logic                  w_mismatch;

    all_gates_golden u_golden (
        .i_idx      (r_idx),
        .o_expected (w_exp)
    );

    assign w_obs      = {xnor_out, xor_out, nor_out, nand_out, not_out, or_out, and_out};
    assign w_diff     = w_obs ^ w_exp;
    assign w_mismatch = |w_diff;

    // idx returns to 0 whenever idle, so the stimulus is simply the index.
    assign {a, b}    = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fvec;
    assign fail_bits = r_fbits;

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_err   = r_err;
        w_fvec  = r_fvec;
        w_fbits = r_fbits;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err   = '0;
                    w_fvec  = '0;
                    w_fbits = '0;
                    w_pass  = 1'b0;
                    w_idx   = '0;
                    w_busy  = 1'b1;
                    w_cnt   = SETTLE_LD;
                    w_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_state = ST_CHECK;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    w_err         = r_err + 3'd1;
                    w_fvec[r_idx] = 1'b1;
                    w_fbits       = r_fbits | w_diff;
                end
                if (r_idx != LAST_IDX) begin
                    w_idx   = r_idx + 2'd1;
                    w_cnt   = SETTLE_LD;
                    w_state = ST_SETTLE;
                end else begin
                    // Final vector: its own mismatch must also veto pass.
                    w_idx   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (r_err == 3'd0) && !w_mismatch;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fvec  <= '0;
            r_fbits <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_fvec  <= w_fvec;
            r_fbits <= w_fbits;
        end
    end

endmodule

// File: tb/tb_all_gates_checker.sv
// Bench for all_gates_checker: two instances (SETTLE_CYCLES 1 and 3) driving
// behavioural gate models with selectable stuck-at faults.
module tb_all_gates_checker;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
        logic [6:0] fb;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    int   mode   = 0;
    int   sel    = 0;

    int n_checks = 0;
    int n_pass   = 0;

    res_t sb_q[$];

    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fv0;
    logic [6:0] fb0, g0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    logic [6:0] fb1, g1;

    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0] m_err;
    logic [3:0] m_fv;
    logic [6:0] m_fb;

    // Correct two-input gate library, bit order AND,OR,NOT,NAND,NOR,XOR,XNOR.
    function automatic logic [6:0] gate_ref(input logic av, input logic bv);
        logic [6:0] r;
        r[0] = av & bv;
        r[1] = av | bv;
        r[2] = !av;
        r[3] = !(av & bv);
        r[4] = !(av | bv);
        r[5] = av ^ bv;
        r[6] = !(av ^ bv);
        return r;
    endfunction

    // mode 1: XOR stuck at 0; mode 2: NAND stuck at 1.
    function automatic logic [6:0] gate_dut(input logic av, input logic bv, input int m);
        logic [6:0] r;
        r = gate_ref(av, bv);
        if (m == 1) r[5] = 1'b0;
        if (m == 2) r[3] = 1'b1;
        return r;
    endfunction

    function automatic res_t expect_run(input int m);
        res_t       e;
        logic [6:0] d;
        logic [1:0] v2;
        e.pass = 1'b0;
        e.err  = '0;
        e.fv   = '0;
        e.fb   = '0;
        for (int v = 0; v < 4; v++) begin
            v2 = 2'(v);
            d  = gate_ref(v2[1], v2[0]) ^ gate_dut(v2[1], v2[0], m);
            if (d != 7'd0) begin
                e.err   = e.err + 3'd1;
                e.fv[v] = 1'b1;
                e.fb    = e.fb | d;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    always_comb g0 = gate_dut(a0, b0, mode);
    always_comb g1 = gate_dut(a1, b1, mode);

    always_comb begin
        if (sel == 0) begin
            {m_a, m_b, m_busy, m_done, m_pass} = {a0, b0, busy0, done0, pass0};
            {m_err, m_fv, m_fb} = {err0, fv0, fb0};
        end else begin
            {m_a, m_b, m_busy, m_done, m_pass} = {a1, b1, busy1, done1, pass1};
            {m_err, m_fv, m_fb} = {err1, fv1, fb1};
        end
    end

    all_gates_checker #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .and_out(g0[0]), .or_out(g0[1]), .not_out(g0[2]), .nand_out(g0[3]),
        .nor_out(g0[4]), .xor_out(g0[5]), .xnor_out(g0[6]),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0), .fail_bits(fb0)
    );

    all_gates_checker #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .and_out(g1[0]), .or_out(g1[1]), .not_out(g1[2]), .nand_out(g1[3]),
        .nor_out(g1[4]), .xor_out(g1[5]), .xnor_out(g1[6]),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1), .fail_bits(fb1)
    );

    task automatic set_start(input int s, input logic v);
        if (s == 0) start0 = v;
        else        start1 = v;
    endtask

    // One complete run; predriven means start is already high before the accepting edge.
    task automatic run(input int s, input int settle, input int m,
                       input bit hold, input bit predriven, input string tag);
        int   n;
        res_t e;
        n    = 4 * (settle + 1);
        sel  = s;
        mode = m;
        if (!predriven) begin
            @(negedge clk);
            set_start(s, 1'b1);
        end
        sb_q.push_back(expect_run(m));
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (!hold && j == 0) set_start(s, 1'b0);
            n_checks++;
            if ({m_a, m_b} !== 2'(j / (settle + 1))) begin
                $display("FAIL %s ab[%0d] got %b want %b", tag, j, {m_a, m_b}, 2'(j / (settle + 1)));
            end else n_pass++;
            n_checks++;
            if ({m_busy, m_done} !== 2'b10) begin
                $display("FAIL %s busy_done[%0d] got %b want 10", tag, j, {m_busy, m_done});
            end else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({m_busy, m_done, m_a, m_b} !== 4'b0100) begin
            $display("FAIL %s end_busy_done_ab got %b want 0100", tag, {m_busy, m_done, m_a, m_b});
        end else n_pass++;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s scoreboard_empty got 0 want 1", tag);
        end else begin
            n_pass++;
            e = sb_q.pop_front();
            n_checks++;
            if (m_pass !== e.pass) $display("FAIL %s pass got %b want %b", tag, m_pass, e.pass);
            else n_pass++;
            n_checks++;
            if (m_err !== e.err) $display("FAIL %s err_count got %0d want %0d", tag, m_err, e.err);
            else n_pass++;
            n_checks++;
            if (m_fv !== e.fv) $display("FAIL %s fail_vec got %b want %b", tag, m_fv, e.fv);
            else n_pass++;
            n_checks++;
            if (m_fb !== e.fb) $display("FAIL %s fail_bits got %b want %b", tag, m_fb, e.fb);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, fv0, fb0} !== 19'd0)
            $display("FAIL reset_dut0 got %h want 0", {a0, b0, busy0, done0, pass0, err0, fv0, fb0});
        else n_pass++;
        n_checks++;
        if ({a1, b1, busy1, done1, pass1, err1, fv1, fb1} !== 19'd0)
            $display("FAIL reset_dut1 got %h want 0", {a1, b1, busy1, done1, pass1, err1, fv1, fb1});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, done0, busy1, done1} !== 4'b0000)
            $display("FAIL idle_after_reset got %b want 0000", {busy0, done0, busy1, done1});
        else n_pass++;
    endtask

    task automatic test_pass_default();
        run(0, 1, 0, 1'b0, 1'b0, "default");
        @(negedge clk);
        n_checks++;
        if ({done0, pass0, busy0} !== 3'b010)
            $display("FAIL done_pulse_pass_hold got %b want 010", {done0, pass0, busy0});
        else n_pass++;
    endtask

    task automatic test_xor_fault();
        run(0, 1, 1, 1'b0, 1'b0, "xor_stuck0");
    endtask

    task automatic test_nand_fault();
        run(0, 1, 2, 1'b0, 1'b0, "nand_stuck1");
    endtask

    task automatic test_settle3();
        run(1, 3, 0, 1'b0, 1'b0, "settle3");
        run(1, 3, 1, 1'b0, 1'b0, "settle3_xor");
    endtask

    task automatic test_busy_start_and_abort();
        sel  = 0;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) start0 = 1'b0;
            if (j == 1) start0 = 1'b1;
            if (j == 2) start0 = 1'b0;
            n_checks++;
            if ({a0, b0, busy0} !== {2'(j / 2), 1'b1})
                $display("FAIL abort_seq[%0d] got %b want %b", j, {a0, b0, busy0}, {2'(j / 2), 1'b1});
            else n_pass++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, fv0, fb0} !== 19'd0)
            $display("FAIL abort_async_reset got %h want 0", {a0, b0, busy0, done0, pass0, err0, fv0, fb0});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_checks++;
            if ({busy0, done0, a0, b0} !== 4'b0000)
                $display("FAIL abort_no_done[%0d] got %b want 0000", j, {busy0, done0, a0, b0});
            else n_pass++;
        end
        run(0, 1, 0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run(0, 1, 0, 1'b1, 1'b0, "b2b_0");
        run(0, 1, 0, 1'b1, 1'b1, "b2b_1");
        run(0, 1, 0, 1'b1, 1'b1, "b2b_2");
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy0, done0, pass0} !== 3'b001)
            $display("FAIL b2b_stop got %b want 001", {busy0, done0, pass0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass_default();
        test_xor_fault();
        test_nand_fault();
        test_settle3();
        test_busy_start_and_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
